// File: rtl/bus_arbiter_driver.sv
// Round-robin arbiter that hands a shared tri-state bus to one of CHANNELS sources,
// with a bounded hold time under contention and a one-cycle turnaround gap between owners.
module bus_arbiter_driver #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          bus,
  output logic                      bus_oe,
  output logic [CHANNELS-1:0]       grant,
  output logic [WIDTH-1:0]          bus_keep,
  output logic                      busy
);

  localparam int              IW        = $clog2(CHANNELS);
  localparam logic [7:0]      HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0]      HOLD_SAT  = 8'(MAX_HOLD);
  localparam logic [IW-1:0]   LAST_CH   = IW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t                state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         owner;
  logic [7:0]            hold_cnt;

  logic [IW-1:0]         cand;
  logic [IW-1:0]         win_idx;
  logic                  win_valid;
  logic [CHANNELS-1:0]   win_onehot;
  logic [WIDTH-1:0]      win_din;
  logic [WIDTH-1:0]      owner_din;
  logic                  owner_req;
  logic                  others_req;
  logic                  preempt;
  logic [IW-1:0]         next_ptr;

  // Scan from the pointer upward with wraparound; the first requester found wins.
  always_comb begin
    cand      = ptr;
    win_idx   = ptr;
    win_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = IW'((int'(ptr) + i) % CHANNELS);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_onehot = {{(CHANNELS-1){1'b0}}, 1'b1} << win_idx;
  assign win_din    = din[int'(win_idx)*WIDTH +: WIDTH];
  assign owner_din  = din[int'(owner)*WIDTH +: WIDTH];
  assign owner_req  = req[owner];
  assign others_req = |(req & ~grant);
  assign preempt    = (hold_cnt == HOLD_LAST) && others_req;
  assign next_ptr   = (owner == LAST_CH) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      bus_oe   <= 1'b0;
      bus_keep <= '0;
    end else begin
      case (state)
        IDLE, TURN: begin
          // The pointer already sits past the previous owner, so it only wins again when alone.
          if (win_valid) begin
            state    <= DRIVE;
            owner    <= win_idx;
            grant    <= win_onehot;
            bus_oe   <= 1'b1;
            hold_cnt <= '0;
            bus_keep <= win_din;
          end else begin
            state  <= IDLE;
            grant  <= '0;
            bus_oe <= 1'b0;
          end
        end
        DRIVE: begin
          bus_keep <= owner_din;
          if (!owner_req || preempt) begin
            state    <= TURN;
            grant    <= '0;
            bus_oe   <= 1'b0;
            ptr      <= next_ptr;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          grant  <= '0;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign bus  = bus_oe ? owner_din : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_arbiter_driver.sv
// Bench for bus_arbiter_driver: two instances (MAX_HOLD 2 and 8) share stimulus and are
// compared every cycle against an abstract arbitration model plus directed literal checks.
module tb_bus_arbiter_driver;

  localparam int W      = 9;
  localparam int CH     = 4;
  localparam int DW     = CH * W;
  localparam int M_IDLE  = 0;
  localparam int M_DRIVE = 1;
  localparam int M_TURN  = 2;
  localparam logic [DW-1:0] DIN_FIXED = {9'h0D4, 9'h0C3, 9'h0B2, 9'h1A5};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] req = '0;
  logic [DW-1:0] din = DIN_FIXED;

  wire  [W-1:0]  bus_a, bus_b;
  logic          oe_a, oe_b;
  logic [CH-1:0] grant_a, grant_b;
  logic [W-1:0]  keep_a, keep_b;
  logic          busy_a, busy_b;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int           mode;
    int           owner;
    int           ptr;
    int           cnt;
    logic [W-1:0] keep;
  } model_t;

  model_t        ma, mb;
  logic [CH-1:0] prev_a = '0;
  logic [CH-1:0] prev_b = '0;

  int rr_own_a [13] = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0};

  bus_arbiter_driver #(.WIDTH(W), .CHANNELS(CH), .MAX_HOLD(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .bus(bus_a), .bus_oe(oe_a), .grant(grant_a), .bus_keep(keep_a), .busy(busy_a)
  );

  bus_arbiter_driver #(.WIDTH(W), .CHANNELS(CH), .MAX_HOLD(8)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .bus(bus_b), .bus_oe(oe_b), .grant(grant_b), .bus_keep(keep_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t m;
    m.mode  = M_IDLE;
    m.owner = 0;
    m.ptr   = 0;
    m.cnt   = 0;
    m.keep  = '0;
    return m;
  endfunction

  function automatic int pick(input logic [CH-1:0] r, input int ptr);
    for (int i = 0; i < CH; i++)
      if (r[(ptr + i) % CH]) return (ptr + i) % CH;
    return -1;
  endfunction

  function automatic model_t model_step(input model_t m, input logic [CH-1:0] r,
                                        input logic [DW-1:0] d, input int maxh);
    model_t n;
    int     w;
    logic   others;
    n = m;
    if (m.mode == M_DRIVE) begin
      n.keep = d[m.owner*W +: W];
      others = (r & ~(CH'(1) << m.owner)) != '0;
      if (!r[m.owner] || (m.cnt == maxh - 1 && others)) begin
        n.mode = M_TURN;
        n.ptr  = (m.owner + 1) % CH;
        n.cnt  = 0;
      end else begin
        n.cnt = (m.cnt == maxh - 1) ? 0 : m.cnt + 1;
      end
    end else begin
      w = pick(r, m.ptr);
      if (w >= 0) begin
        n.mode  = M_DRIVE;
        n.owner = w;
        n.cnt   = 0;
        n.keep  = d[w*W +: W];
      end else begin
        n.mode = M_IDLE;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, req, din, 2);
      mb <= model_step(mb, req, din, 8);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag, input model_t m, input logic [CH-1:0] g,
                               input logic oe, input logic [W-1:0] b, input logic [W-1:0] k,
                               input logic bz, input logic [CH-1:0] prev);
    logic [CH-1:0] eg;
    logic          drive;
    drive = (m.mode == M_DRIVE);
    eg    = drive ? CH'(1) << m.owner : '0;
    cmp({tag, "_grant"}, 32'(g), 32'(eg));
    cmp({tag, "_oe"}, 32'(oe), 32'(drive));
    cmp({tag, "_busy"}, 32'(bz), 32'(m.mode != M_IDLE));
    cmp({tag, "_keep"}, 32'(k), 32'(m.keep));
    if (drive) cmp({tag, "_bus"}, 32'(b), 32'(din[m.owner*W +: W]));
    cmp({tag, "_onehot"}, 32'($countones(g) <= 1), 32'd1);
    cmp({tag, "_oe_or"}, 32'(oe), 32'(|g));
    cmp({tag, "_no_overlap"}, 32'(prev != '0 && g != '0 && prev != g), 32'd0);
  endtask

  // Single compare process: both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    compare_model("model_a", ma, grant_a, oe_a, bus_a, keep_a, busy_a, prev_a);
    compare_model("model_b", mb, grant_b, oe_b, bus_b, keep_b, busy_b, prev_b);
    prev_a <= grant_a;
    prev_b <= grant_b;
  end

  function automatic logic [CH-1:0] oh(input int c);
    if (c < 0) return '0;
    return CH'(1) << c;
  endfunction

  function automatic logic [W-1:0] din_of(input int c);
    if (c < 0) return '0;
    return din[c*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [CH-1:0] r);
    req = r;
  endtask

  task automatic check_output(input string name, input int which, input logic [CH-1:0] eg,
                              input logic [W-1:0] eb);
    logic [CH-1:0] g;
    logic          oe;
    logic [W-1:0]  b;
    g  = (which == 0) ? grant_a : grant_b;
    oe = (which == 0) ? oe_a : oe_b;
    b  = (which == 0) ? bus_a : bus_b;
    cmp({name, "_grant"}, 32'(g), 32'(eg));
    cmp({name, "_oe"}, 32'(oe), 32'(eg != '0));
    if (eg != '0) cmp({name, "_bus"}, 32'(b), 32'(eb));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    for (int w = 0; w < 2; w++) check_output($sformatf("reset%0d", w), w, '0, '0);
    cmp("reset_keep_a", 32'(keep_a), 32'd0);
    cmp("reset_busy_b", 32'(busy_b), 32'd0);

    // All channels requesting: short-hold instance rotates every two cycles.
    rst = 1'b0;
    apply_stimulus(4'b1111);
    for (int i = 0; i < 13; i++) begin
      int own_b;
      tick();
      own_b = (i <= 7) ? 0 : (i == 8) ? -1 : 1;
      check_output($sformatf("rr%0d_a", i), 0, oh(rr_own_a[i]), din_of(rr_own_a[i]));
      check_output($sformatf("rr%0d_b", i), 1, oh(own_b), din_of(own_b));
    end
    apply_stimulus('0);
    repeat (3) tick();
    pulse_reset();

    apply_stimulus(4'b0001);
    tick();
    check_output("single_a", 0, 4'b0001, 9'h1A5);
    check_output("single_b", 1, 4'b0001, 9'h1A5);
    cmp("single_keep_a", 32'(keep_a), 32'h1A5);
    apply_stimulus('0);
    tick();
    check_output("turn_a", 0, '0, '0);
    cmp("turn_busy_a", 32'(busy_a), 32'd1);
    cmp("turn_keep_a", 32'(keep_a), 32'h1A5);
    tick();
    check_output("idle_a", 0, '0, '0);
    cmp("idle_busy_a", 32'(busy_a), 32'd0);
    cmp("idle_keep_b", 32'(keep_b), 32'h1A5);

    // Pointer walks to 3 so channel 3 beats channel 0, then wraps back to 0.
    apply_stimulus(4'b0100);
    tick();
    check_output("wrap_c2_a", 0, 4'b0100, 9'h0C3);
    apply_stimulus(4'b1001);
    tick();
    check_output("wrap_turn_b", 1, '0, '0);
    tick();
    check_output("wrap_c3_a", 0, 4'b1000, 9'h0D4);
    check_output("wrap_c3_b", 1, 4'b1000, 9'h0D4);
    apply_stimulus(4'b0001);
    tick();
    check_output("wrap_turn2_a", 0, '0, '0);
    tick();
    check_output("wrap_c0_a", 0, 4'b0001, 9'h1A5);
    check_output("wrap_c0_b", 1, 4'b0001, 9'h1A5);
    apply_stimulus('0);
    repeat (2) tick();
    pulse_reset();

    apply_stimulus(4'b0100);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_output($sformatf("sole%0d_a", i), 0, 4'b0100, 9'h0C3);
      check_output($sformatf("sole%0d_b", i), 1, 4'b0100, 9'h0C3);
    end
    apply_stimulus('0);
    repeat (2) tick();

    // Reset between edges must release the bus immediately.
    apply_stimulus(4'b0010);
    tick();
    check_output("mid_pre_a", 0, 4'b0010, 9'h0B2);
    #2 rst = 1'b1;
    #1;
    check_output("mid_rst_a", 0, '0, '0);
    check_output("mid_rst_b", 1, '0, '0);
    cmp("mid_rst_keep_a", 32'(keep_a), 32'd0);
    cmp("mid_rst_busy_b", 32'(busy_b), 32'd0);
    #2 rst = 1'b0;
    tick();
    check_output("post_rst_a", 0, 4'b0010, 9'h0B2);
    check_output("post_rst_b", 1, 4'b0010, 9'h0B2);
    apply_stimulus('0);
    repeat (2) tick();

    for (int i = 0; i < 90; i++) begin
      if (i % 3 == 0) apply_stimulus(CH'($urandom_range(0, 15)));
      din = DW'({$urandom, $urandom});
      tick();
    end
    apply_stimulus('0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
